// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Loads a software image into instruction memory from a byte stream and
//   keeps the core in reset until the image has been written completely.
//   Frame format: LEN_LO, LEN_HI (word count N, little-endian), then 4*N data
//   bytes, each word little-endian (first byte lands in [7:0]).
//
//   Optional build macro: BOOT_CSUM_EN
//     When defined, one extra byte follows the data; it must equal the XOR of
//     all data bytes (0x00 for an empty image). A mismatch ends in the error
//     state with the core still held.
//
// Ports
//   clk           core clock
//   rst           synchronous reset, active low
//   in_data       stream byte
//   in_valid      in_data valid
//   in_ready      loader can accept a byte this cycle
//   imem_we       one-cycle instruction memory write strobe
//   imem_addr     word address of the write
//   imem_wdata    word to write
//   core_hold     1 = keep the core in reset
//   load_done     image loaded successfully (sticky until rst)
//   load_err      protocol error (sticky until rst)
//   words_loaded  number of words written so far
//
// States
//   S_LEN0 | waiting for low byte of the word count
//   S_LEN1 | waiting for high byte of the word count
//   S_DATA | receiving data bytes, writing one word per 4 bytes
//   S_CSUM | waiting for the checksum byte (BOOT_CSUM_EN only)
//   S_DONE | image complete, core released
//   S_ERR  | protocol error, core held

module imem_boot_loader #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          core_hold,
  output logic          load_done,
  output logic          load_err,
  output logic [15:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_LEN0 = 3'd0,
    S_LEN1 = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t      state;
  state_t      state_nxt;
  state_t      state_post;   // where the FSM goes once the data phase is over
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [15:0] len_full;
  logic [1:0]  bcnt;
  logic [23:0] wbuf;
  logic        data_cmpl;    // last data byte taken, final write still pending
  logic        acc;
  logic        last_byte;
`ifdef BOOT_CSUM_EN
  logic [7:0]  csum;
`endif

`ifdef BOOT_CSUM_EN
  assign state_post = S_CSUM;
`else
  assign state_post = S_DONE;
`endif

  // Ready is withheld during the final write cycle so no byte can slip in
  // between the last data byte and the end of the data phase.
  assign in_ready = rst && ((state == S_LEN0) || (state == S_LEN1) ||
                            (state == S_CSUM) ||
                            ((state == S_DATA) && !data_cmpl));

  assign acc       = in_valid && in_ready;
  assign len_full  = {in_data, len_lo};
  // The previous word's write has always retired by the next 4th byte, so
  // words_loaded here equals the index of the word being completed.
  assign last_byte = (state == S_DATA) && acc && (bcnt == 2'd3) &&
                     ((words_loaded + 16'd1) == len);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_LEN0;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    core_hold = 1'b1;
    load_done = 1'b0;
    load_err  = 1'b0;
    case (state)
      S_LEN0: begin
        if (acc) state_nxt = S_LEN1;
      end
      S_LEN1: begin
        if (acc) begin
          if (len_full == 16'd0)              state_nxt = state_post;
          else if (len_full > 16'(DEPTH))     state_nxt = S_ERR;
          else                                state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (imem_we && data_cmpl) state_nxt = state_post;
      end
      S_CSUM: begin
`ifdef BOOT_CSUM_EN
        if (acc) state_nxt = (in_data == csum) ? S_DONE : S_ERR;
`else
        state_nxt = S_ERR;
`endif
      end
      S_DONE: begin
        core_hold = 1'b0;
        load_done = 1'b1;
      end
      S_ERR: begin
        load_err = 1'b1;
      end
      default: begin
        state_nxt = S_LEN0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      len_lo       <= '0;
      len          <= '0;
      bcnt         <= '0;
      wbuf         <= '0;
      data_cmpl    <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      words_loaded <= '0;
`ifdef BOOT_CSUM_EN
      csum         <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      if (imem_we) words_loaded <= words_loaded + 16'd1;
      if ((state == S_LEN0) && acc) len_lo <= in_data;
      if ((state == S_LEN1) && acc) len    <= len_full;
      if ((state == S_DATA) && acc) begin
        bcnt <= bcnt + 2'd1;
        wbuf <= {in_data, wbuf[23:8]};
`ifdef BOOT_CSUM_EN
        csum <= csum ^ in_data;
`endif
        if (bcnt == 2'd3) begin
          imem_we    <= 1'b1;
          imem_wdata <= {in_data, wbuf};
          imem_addr  <= words_loaded[AW-1:0];
        end
        if (last_byte) data_cmpl <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_hold;
  logic          load_done;
  logic          load_err;
  logic [15:0]   words_loaded;

  imem_boot_loader #(.DEPTH(1024), .AW(AW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_hold(core_hold), .load_done(load_done),
    .load_err(load_err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_fail = 0;
  logic [41:0]   exp_q[$];
  logic [41:0]   mon_e;
  int            cyc = 0;
  int            we_count = 0;
  int            last_we_cyc = -1;
  int            hold_fall_cyc = -1;
  logic          prev_hold = 1'b1;
  int            stalls = 0;
  int            we0;
  logic [7:0]    csum = 8'h00;
  logic [AW-1:0] exp_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Write monitor: every strobe must match the next expected (addr, data).
  always @(negedge clk) begin
    if (prev_hold && !core_hold) hold_fall_cyc = cyc;
    prev_hold = core_hold;
    if (rst && imem_we) begin
      we_count++;
      last_we_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", imem_addr, imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(imem_addr), 32'(mon_e[41:32]));
        check("wr_data", imem_wdata, mon_e[31:0]);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    for (int t = 0; t < 50 && !in_ready; t++) begin
      stalls++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL byte_timeout: got in_ready 0 expected 1");
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit rnd_gap);
    exp_q.push_back({exp_addr, w});
    exp_addr = exp_addr + 1'b1;
    for (int i = 0; i < 4; i++) begin
      csum = csum ^ w[8*i +: 8];
      send_byte(w[8*i +: 8], rnd_gap ? int'($urandom_range(1, 5)) : 0);
    end
  endtask

  task automatic wait_end();
    bit seen = 1'b0;
    idle();
    for (int t = 0; t < 200; t++) begin
      if (load_done || load_err) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL end_timeout: got neither load_done nor load_err expected one");
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_hold", 32'(core_hold), 32'd1);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_err", 32'(load_err), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    rst = 1'b1;
    exp_addr = '0;
    csum = 8'h00;
    hold_fall_cyc = -1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    do_reset();

    // Test 1: three words at full rate
    we0 = we_count;
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    stalls = 0;
    send_word(32'h00A00513, 1'b0);
    send_word(32'h00B00593, 1'b0);
    send_word(32'h20B5A633, 1'b0);
    check("t1_stalls", 32'(stalls), 32'd0);
`ifdef BOOT_CSUM_EN
    send_byte(csum, 0);
`endif
    wait_end();
    check("t1_done", 32'(load_done), 32'd1);
    check("t1_err", 32'(load_err), 32'd0);
    check("t1_hold", 32'(core_hold), 32'd0);
    check("t1_in_ready", 32'(in_ready), 32'd0);
    check("t1_words", 32'(words_loaded), 32'd3);
    check("t1_we_count", 32'(we_count - we0), 32'd3);
`ifndef BOOT_CSUM_EN
    check("t1_hold_fall", 32'(hold_fall_cyc), 32'(last_we_cyc + 1));
`endif

    // Test 2: empty image
    do_reset();
    we0 = we_count;
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef BOOT_CSUM_EN
    send_byte(8'h00, 0);
`endif
    wait_end();
    check("t2_done", 32'(load_done), 32'd1);
    check("t2_hold", 32'(core_hold), 32'd0);
    check("t2_words", 32'(words_loaded), 32'd0);
    check("t2_we_count", 32'(we_count - we0), 32'd0);

    // Test 3: length DEPTH+1 rejected; later bytes refused
    do_reset();
    we0 = we_count;
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    wait_end();
    @(negedge clk);
    in_data  = 8'h5A;
    in_valid = 1'b1;
    repeat (6) @(negedge clk);
    in_valid = 1'b0;
    check("t3_err", 32'(load_err), 32'd1);
    check("t3_done", 32'(load_done), 32'd0);
    check("t3_in_ready", 32'(in_ready), 32'd0);
    check("t3_hold", 32'(core_hold), 32'd1);
    check("t3_words", 32'(words_loaded), 32'd0);
    check("t3_we_count", 32'(we_count - we0), 32'd0);

    // Test 4: two words with random valid gaps
    do_reset();
    we0 = we_count;
    send_byte(8'h02, 2);
    send_byte(8'h00, 3);
    send_word(32'h12345678, 1'b1);
    send_word(32'hDEADBEEF, 1'b1);
`ifdef BOOT_CSUM_EN
    send_byte(csum, 2);
`endif
    wait_end();
    check("t4_done", 32'(load_done), 32'd1);
    check("t4_words", 32'(words_loaded), 32'd2);
    check("t4_we_count", 32'(we_count - we0), 32'd2);

    // Test 5: reset mid-word, then a one-word frame
    do_reset();
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    send_word(32'hCAFEF00D, 1'b0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    idle();
    repeat (3) @(negedge clk);
    check("t5_partial_words", 32'(words_loaded), 32'd1);
    check("t5_partial_hold", 32'(core_hold), 32'd1);
    check("t5_pending", 32'(exp_q.size()), 32'd0);
    do_reset();
    we0 = we_count;
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_word(32'hDDCCBBAA, 1'b0);
`ifdef BOOT_CSUM_EN
    send_byte(csum, 0);
`endif
    wait_end();
    check("t5_done", 32'(load_done), 32'd1);
    check("t5_words", 32'(words_loaded), 32'd1);
    check("t5_we_count", 32'(we_count - we0), 32'd1);

`ifdef BOOT_CSUM_EN
    // Test 6: checksum good then bad (XOR of 11 22 33 44 is 44)
    do_reset();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_word(32'h44332211, 1'b0);
    send_byte(8'h44, 0);
    wait_end();
    check("t6_good_done", 32'(load_done), 32'd1);
    check("t6_good_err", 32'(load_err), 32'd0);
    do_reset();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_word(32'h44332211, 1'b0);
    send_byte(8'h45, 0);
    wait_end();
    check("t6_bad_err", 32'(load_err), 32'd1);
    check("t6_bad_done", 32'(load_done), 32'd0);
    check("t6_bad_hold", 32'(core_hold), 32'd1);
`endif

    repeat (3) @(negedge clk);
    check("final_pending", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
